serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial N-bit adder stage wrapping one full-adder bit cell plus a registered carry.
//  Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
//  Feeds the bit cell one bit pair per clock, LSB first, and collects the sum bits.
//  Presents the WIDTH-bit sum and carry-out downstream over a second valid/ready handshake.
//  Trades WIDTH cycles of latency for one adder cell; used where area beats throughput.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range >= 1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      upstream operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to bit 0
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  busy       out  1      high in SHIFT state
// BEHAVIOUR
//  - Reset: async, active-low. While rst_n=0:
//    - state=IDLE; all shift registers, carry register and counter are 0.
//    - in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready: latch a->a_sh, b->b_sh, cin->carry_q; clear sum_sh; cnt=0; go to SHIFT.
//  - SHIFT: in_ready=0, busy=1. Each cycle:
//    - Bit cell computes s,c from a_sh[0], b_sh[0], carry_q.
//    - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
//    - a_sh and b_sh shift right one bit; carry_q <= c; cnt++.
//    - When cnt==WIDTH-1 that cycle: go to DONE.
//  - DONE:
//    - out_valid=1; sum=sum_sh; cout=carry_q. Both are stable while out_valid=1 and out_ready=0.
//    - On out_ready: go to IDLE; out_valid drops next cycle.
//  - Latency: the accept edge is cycle 0; out_valid is first high after edge WIDTH (WIDTH SHIFT cycles).
//  - Throughput: one add per WIDTH+2 cycles minimum; DONE and IDLE are never overlapped.
//  - Back-pressure: in_valid is ignored outside IDLE; a, b and cin need only be stable at the accept edge.
//  - out_ready is ignored outside DONE.
//  - sum/cout hold their last value in IDLE; they are don't-care unless out_valid=1.
//  - Reset mid-operation: the operation is aborted and no partial result is ever flagged valid.
//  - Width rules:
//    - cnt is $clog2(WIDTH+1) bits wide.
//    - WIDTH=1: exactly one SHIFT cycle.
//    - Overflow never saturates; it is reported only through cout.
// STRUCTURE
//  - Package serial_add_pkg:
//    - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sadd_state_t
//    - localparam DEFAULT_WIDTH = 8
//  - One sub-module: full_adder_structural, instantiated once as the bit cell.
//  - FSM, counter, shift registers and carry register are in this module.
// TESTING
//  1. WIDTH=8, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0; out_valid first high exactly 8 cycles after accept.
//  2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
//  3. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//  4. Case 1 with out_ready=0 for 5 cycles:
//     -> out_valid and sum=0x96 held; in_ready=0 throughout; in_valid pulses ignored.
//  5. Drop rst_n at the 3rd SHIFT cycle -> outputs immediately at reset values.
//     -> A new add after release (0x01+0x02) returns 0x03, cout=0.
//  6. WIDTH=1, all 8 (a,b,cin) combos -> {cout,sum}=a+b+cin; out_valid 1 cycle after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and defaults for the bit-serial adder
//
// Contents:
//   sadd_state_t   controller state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  default operand/sum width in bits
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sadd_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_structural.sv
// rtl/full_adder_structural.sv - one-bit full adder built from gate primitives
//
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit        (a ^ b ^ ci)
//   co    out  carry out      (a & b) | (ci & (a ^ b))
module full_adder_structural (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g;
    logic t;

    xor u_xor_p (p, a, b);
    xor u_xor_s (s, p, ci);
    and u_and_g (g, a, b);
    and u_and_t (t, p, ci);
    or  u_or_co (co, g, t);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder around a single full-adder cell
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  operands accepted (high only in IDLE)
//   a, b       in   WIDTH-bit operands, sampled at the accept edge
//   cin        in   carry into bit 0, sampled at the accept edge
//   out_valid  out  sum/cout valid (high only in DONE)
//   out_ready  in   downstream takes the result
//   sum        out  a + b + cin modulo 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   busy       out  high while bits are being shifted through the cell
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sadd_state_t state_q;
    sadd_state_t state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic bit_s;
    logic bit_c;
    logic accept;
    logic shift_en;

    full_adder_structural u_bit_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
    always_comb begin
        sum_next            = sum_sh >> 1;
        sum_next[WIDTH-1]   = bit_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            sum_sh  <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (shift_en) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_sh  <= sum_next;
            carry_q <= bit_c;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Registers are untouched between DONE and the next accept, so the result holds.
    assign sum  = sum_sh;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH 8 and 1
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready8"},  32'(in_ready8),  32'd1);
        check({tag, "_out_valid8"}, 32'(out_valid8), 32'd0);
        check({tag, "_sum8"},       32'(sum8),       32'd0);
        check({tag, "_cout8"},      32'(cout8),      32'd0);
        check({tag, "_busy8"},      32'(busy8),      32'd0);
        check({tag, "_in_ready1"},  32'(in_ready1),  32'd1);
        check({tag, "_out_valid1"}, 32'(out_valid1), 32'd0);
    endtask

    // Drives one add on the WIDTH=8 instance; stall holds out_ready low in DONE.
    task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input int stall);
        int lat;
        logic [8:0] exp;
        logic [8:0] held;
        @(negedge clk);
        check("idle_in_ready8", 32'(in_ready8), 32'd1);
        a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
        q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
        @(negedge clk);
        // Operands only need to be valid at the accept edge.
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            in_valid8 = lat[0];
            if (busy8 !== 1'b1 || in_ready8 !== 1'b0) check("shift_flags8", {30'd0, busy8, in_ready8}, 32'h2);
            @(negedge clk);
            lat++;
        end
        check("latency8", 32'(lat), 32'd8);
        held = {cout8, sum8};
        for (int i = 0; i < stall; i++) begin
            in_valid8 = 1'b1;
            check("stall_out_valid8", 32'(out_valid8), 32'd1);
            check("stall_hold8", 32'({cout8, sum8}), 32'(held));
            check("stall_in_ready8", 32'(in_ready8), 32'd0);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        check("out_valid8", 32'(out_valid8), 32'd1);
        if (q8.size() == 0) begin
            check("q8_empty", 32'd0, 32'd1);
        end else begin
            exp = q8.pop_front();
            check("result8", 32'({cout8, sum8}), 32'(exp));
        end
        @(negedge clk);
        out_ready8 = 1'b0;
        check("drop_out_valid8", 32'(out_valid8), 32'd0);
        check("back_in_ready8", 32'(in_ready8), 32'd1);
    endtask

    task automatic add1(input logic av, input logic bv, input logic cv);
        int lat;
        logic [1:0] exp;
        @(negedge clk);
        check("idle_in_ready1", 32'(in_ready1), 32'd1);
        a1 = av; b1 = bv; cin1 = cv; in_valid1 = 1'b1;
        q1.push_back({1'b0, av} + {1'b0, bv} + {1'b0, cv});
        @(negedge clk);
        in_valid1 = 1'b0;
        a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency1", 32'(lat), 32'd1);
        out_ready1 = 1'b1;
        exp = q1.pop_front();
        check("result1", 32'({cout1, sum1}), 32'(exp));
        @(negedge clk);
        out_ready1 = 1'b0;
        check("drop_out_valid1", 32'(out_valid1), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        add8(8'h5A, 8'h3C, 1'b0, 0);
        add8(8'hFF, 8'h01, 1'b0, 0);
        add8(8'hFF, 8'hFF, 1'b1, 0);
        add8(8'h5A, 8'h3C, 1'b0, 5);
        add8(8'h00, 8'h00, 1'b0, 1);
        add8(8'h80, 8'h80, 1'b1, 2);

        // Abort in the third SHIFT cycle; nothing may come out afterwards.
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_busy8", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid8 !== 1'b0) check("post_abort_valid8", 32'(out_valid8), 32'd0);
        end
        check("post_abort_idle8", 32'(in_ready8), 32'd1);
        add8(8'h01, 8'h02, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            add1(v[2], v[1], v[0]);
        end

        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
